check_level_ctrl: RTL and testbench

CHECK_LEVEL_CTRL -- requirements
Module: check_level_ctrl

---
 rtl/check_level_pkg.sv | 17 +
 rtl/check_level_sel.sv | 27 ++
 rtl/check_level_ctrl.sv | 176 +++++++++++++++++
 tb/tb_check_level_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/check_level_pkg.sv
// Shared types for the check-level controller: command opcodes and FSM states.
package check_level_pkg;

  typedef enum logic [1:0] {
    CHK     = 2'b00,
    WAIT_EQ = 2'b01,
    STABLE  = 2'b10,
    RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/check_level_sel.sv
// Selects one monitored signal from the flattened bus and compares it
// against an expected value under a bit mask.
module check_level_sel #(
  parameter int unsigned CHECK_SIZE  = 5,
  parameter int unsigned CHECK_WIDTH = 32
) (
  input  logic [CHECK_SIZE*CHECK_WIDTH-1:0] bus,
  input  logic [$clog2(CHECK_SIZE)-1:0]     idx,
  input  logic [CHECK_WIDTH-1:0]            value,
  input  logic [CHECK_WIDTH-1:0]            mask,
  output logic [CHECK_WIDTH-1:0]            sel,
  output logic                              match
);

  localparam int unsigned IDX_W = $clog2(CHECK_SIZE);

  // Out-of-range indices select zero rather than reading past the bus.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < CHECK_SIZE; k++) begin
      if (idx == IDX_W'(k)) sel = bus[k*CHECK_WIDTH +: CHECK_WIDTH];
    end
  end

  assign match = ((sel ^ value) & mask) == '0;

endmodule

// File: rtl/check_level_ctrl.sv
// Command-driven signal checker: samples one monitored signal per cycle and
// reports pass/fail for CHK, WAIT_EQ and STABLE operations.
module check_level_ctrl
  import check_level_pkg::*;
#(
  parameter int unsigned CHECK_SIZE  = 5,
  parameter int unsigned CHECK_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHECK_SIZE*CHECK_WIDTH-1:0] check_signals_i,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [$clog2(CHECK_SIZE)-1:0]     cmd_idx,
  input  logic [CHECK_WIDTH-1:0]            cmd_value,
  input  logic [CHECK_WIDTH-1:0]            cmd_mask,
  input  logic [CNT_WIDTH-1:0]              cmd_cycles,
  input  logic                              abort_i,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_pass,
  output logic                              rsp_error,
  output logic [CNT_WIDTH-1:0]              rsp_samples,
  output logic [CHECK_WIDTH-1:0]            rsp_value,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              pass_cnt,
  output logic [CNT_WIDTH-1:0]              fail_cnt
);

  localparam int unsigned IDX_W = $clog2(CHECK_SIZE);

  state_e                  state, state_nxt;
  op_e                     op_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CHECK_WIDTH-1:0]  value_q, mask_q;
  logic [CNT_WIDTH-1:0]    limit_q, cnt_q;

  logic [CHECK_WIDTH-1:0]  sel_value;
  logic                    match;
  logic [CNT_WIDTH-1:0]    sample_cnt;
  logic                    last;
  logic                    cmd_fire, cmd_bad;
  logic                    decide, dec_pass, dec_error;

  check_level_sel #(
    .CHECK_SIZE  (CHECK_SIZE),
    .CHECK_WIDTH (CHECK_WIDTH)
  ) u_sel (
    .bus   (check_signals_i),
    .idx   (idx_q),
    .value (value_q),
    .mask  (mask_q),
    .sel   (sel_value),
    .match (match)
  );

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign cmd_fire   = cmd_valid && (state == IDLE);
  assign cmd_bad    = (cmd_op == 2'b11) || (32'(cmd_idx) >= CHECK_SIZE);
  // cnt_q < limit_q in RUN, so the increment can never wrap.
  assign sample_cnt = cnt_q + CNT_WIDTH'(1);
  assign last       = (sample_cnt >= limit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-sample decision; abort outranks any decision.
  always_comb begin
    state_nxt = state;
    decide    = 1'b0;
    dec_pass  = 1'b0;
    dec_error = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = cmd_bad ? RESP : RUN;
      end
      RUN: begin
        if (abort_i) begin
          decide    = 1'b1;
          dec_error = 1'b1;
        end else begin
          case (op_q)
            CHK: begin
              decide   = 1'b1;
              dec_pass = match;
            end
            WAIT_EQ: begin
              if (match) begin
                decide   = 1'b1;
                dec_pass = 1'b1;
              end else if (last) begin
                decide = 1'b1;
              end
            end
            STABLE: begin
              if (!match) begin
                decide = 1'b1;
              end else if (last) begin
                decide   = 1'b1;
                dec_pass = 1'b1;
              end
            end
            default: begin
              decide    = 1'b1;
              dec_error = 1'b1;
            end
          endcase
        end
        if (decide) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, sample counting and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= CHK;
      idx_q       <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      limit_q     <= '0;
      cnt_q       <= '0;
      rsp_pass    <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_samples <= '0;
      rsp_value   <= '0;
    end else begin
      if (cmd_fire) begin
        op_q    <= op_e'(cmd_op);
        idx_q   <= cmd_idx;
        value_q <= cmd_value;
        mask_q  <= cmd_mask;
        limit_q <= (cmd_cycles == '0) ? CNT_WIDTH'(1) : cmd_cycles;
        cnt_q   <= '0;
        if (cmd_bad) begin
          rsp_pass    <= 1'b0;
          rsp_error   <= 1'b1;
          rsp_samples <= '0;
          rsp_value   <= '0;
        end
      end
      if (state == RUN) cnt_q <= sample_cnt;
      if (decide) begin
        rsp_pass    <= dec_pass;
        rsp_error   <= dec_error;
        rsp_samples <= sample_cnt;
        rsp_value   <= sel_value;
      end
    end
  end

  // Saturating statistics, updated on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if ((state == RESP) && rsp_ready) begin
      if (rsp_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_check_level_ctrl.sv
// Directed plus randomized bench for check_level_ctrl against a sample-list
// reference model of the CHK / WAIT_EQ / STABLE rules.
module tb_check_level_ctrl;

  localparam int unsigned CS = 5;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 4;
  localparam int          CNT_MAX = (1 << NW) - 1;

  logic              clk;
  logic              rst_n;
  logic [CS*CW-1:0]  check_signals_i;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [2:0]        cmd_idx;
  logic [CW-1:0]     cmd_value;
  logic [CW-1:0]     cmd_mask;
  logic [NW-1:0]     cmd_cycles;
  logic              abort_i;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_pass;
  logic              rsp_error;
  logic [NW-1:0]     rsp_samples;
  logic [CW-1:0]     rsp_value;
  logic              busy;
  logic [NW-1:0]     pass_cnt;
  logic [NW-1:0]     fail_cnt;

  int checks = 0;
  int errors = 0;
  int exp_pass_cnt = 0;
  int exp_fail_cnt = 0;
  logic [31:0] seq [0:31];

  check_level_ctrl #(
    .CHECK_SIZE  (CS),
    .CHECK_WIDTH (CW),
    .CNT_WIDTH   (NW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .check_signals_i (check_signals_i),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_idx         (cmd_idx),
    .cmd_value       (cmd_value),
    .cmd_mask        (cmd_mask),
    .cmd_cycles      (cmd_cycles),
    .abort_i         (abort_i),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_pass        (rsp_pass),
    .rsp_error       (rsp_error),
    .rsp_samples     (rsp_samples),
    .rsp_value       (rsp_value),
    .busy            (busy),
    .pass_cnt        (pass_cnt),
    .fail_cnt        (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the sample list under the op's rule.
  function automatic void ref_model(input int op, input int l, input logic [31:0] value,
                                    input logic [31:0] mask, output logic p, output int n,
                                    output logic [31:0] v);
    int  lim;
    logic m;
    lim = (l == 0) ? 1 : l;
    p = (op == 2);
    n = lim;
    v = seq[lim-1];
    for (int i = 0; i < lim; i++) begin
      m = ((seq[i] ^ value) & mask) == 32'h0;
      if (op == 0) begin p = m; n = 1; v = seq[0]; return; end
      if (op == 1 && m) begin p = 1'b1; n = i + 1; v = seq[i]; return; end
      if (op == 2 && !m) begin p = 1'b0; n = i + 1; v = seq[i]; return; end
    end
  endfunction

  task automatic set_bus(input int idx, input logic [31:0] v);
    for (int k = 0; k < CS; k++)
      check_signals_i[k*CW +: CW] = (k == idx) ? v : $urandom();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  // Issue one command, follow it to the response and consume it.
  task automatic run_cmd(input int op, input int idx, input int l, input logic [31:0] value,
                         input logic [31:0] mask, input int abort_at, input int hold,
                         input string tag);
    logic        exp_p, exp_err, aborted;
    int          exp_n, exp_lat, c;
    logic [31:0] exp_v;
    logic [63:0] snap;
    exp_p = 1'b0; exp_n = 0; exp_v = '0; aborted = 1'b0;
    exp_err = (op == 3) || (idx >= CS);
    check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    if (exp_err) begin
      exp_lat = 1;
    end else begin
      ref_model(op, l, value, mask, exp_p, exp_n, exp_v);
      if (abort_at > 0 && abort_at <= exp_n) begin
        aborted = 1'b1;
        exp_err = 1'b1;
        exp_p   = 1'b0;
        exp_lat = abort_at + 1;
      end else begin
        abort_at = 0;
        exp_lat  = exp_n + 1;
      end
    end
    cmd_valid  = 1'b1;
    cmd_op     = 2'(op);
    cmd_idx    = 3'(idx);
    cmd_value  = value;
    cmd_mask   = mask;
    cmd_cycles = NW'(l);
    set_bus(idx, $urandom());
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_value = $urandom();
    cmd_mask  = $urandom();
    c = 1;
    while (c < 40) begin
      if (rsp_valid) break;
      set_bus(idx, (c - 1 < 32) ? seq[c-1] : $urandom());
      abort_i = (c == abort_at);
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(exp_lat));
    if (!rsp_valid) begin
      do_reset();
      return;
    end
    check({tag, "_pass"}, 64'(rsp_pass), 64'(exp_p));
    check({tag, "_error"}, 64'(rsp_error), 64'(exp_err));
    if (!aborted) begin
      check({tag, "_samples"}, 64'(rsp_samples), 64'(exp_n));
      if (!exp_err) check({tag, "_value"}, 64'(rsp_value), 64'(exp_v));
    end
    check({tag, "_no_accept_in_resp"}, 64'(cmd_ready), 64'(0));
    snap = {26'h0, rsp_pass, rsp_error, rsp_samples, rsp_value};
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      abort_i   = 1'($urandom());
      set_bus(idx, $urandom());
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
      check({tag, "_hold_stable"}, {26'h0, rsp_pass, rsp_error, rsp_samples, rsp_value}, snap);
    end
    abort_i   = 1'b0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    if (exp_p) exp_pass_cnt = (exp_pass_cnt < CNT_MAX) ? exp_pass_cnt + 1 : CNT_MAX;
    else       exp_fail_cnt = (exp_fail_cnt < CNT_MAX) ? exp_fail_cnt + 1 : CNT_MAX;
    check({tag, "_idle_after"}, 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass_cnt));
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(exp_fail_cnt));
  endtask

  initial begin
    logic [31:0] v, m;
    int op, idx, l, ab;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_value = '0;
    cmd_mask = '0; cmd_cycles = '0; abort_i = 1'b0; rsp_ready = 1'b0;
    check_signals_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({cmd_ready, busy, rsp_valid, rsp_pass, rsp_error}), 64'(5'b10000));
    check("reset_cnts", 64'({pass_cnt, fail_cnt, rsp_samples}), 64'(0));
    check("reset_value", 64'(rsp_value), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(cmd_ready), 64'(1));
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("abort_in_idle", 64'({busy, cmd_ready}), 64'(2'b01));

    // CHK on signal 2
    seq[0] = 32'h0000_00A5;
    run_cmd(0, 2, 1, 32'hA5, 32'hFF, 0, 0, "chk_a5");

    // WAIT_EQ matches on 4th sample, then never matches
    v = 32'h1234_5678;
    for (int i = 0; i < 32; i++) seq[i] = v ^ 32'h8000_0000;
    seq[3] = v;
    run_cmd(1, 0, 10, v, 32'hFFFF_FFFF, 0, 1, "wait_hit4");
    for (int i = 0; i < 32; i++) seq[i] = v ^ (32'h1 << (i % 32));
    run_cmd(1, 0, 10, v, 32'hFFFF_FFFF, 0, 0, "wait_timeout");

    // STABLE mismatch on 5th sample
    for (int i = 0; i < 32; i++) seq[i] = 32'hCAFE_0000;
    seq[4] = 32'hCAFE_0010;
    run_cmd(2, 1, 8, 32'hCAFE_0000, 32'hFFFF_FFFF, 0, 0, "stable_break5");

    // Invalid index and reserved op
    run_cmd(0, 5, 3, 32'h0, 32'h0, 0, 0, "bad_idx");
    run_cmd(3, 1, 3, 32'h0, 32'h0, 0, 2, "bad_op");

    // Abort in 3rd cycle coincident with a match; hold response 5 cycles
    for (int i = 0; i < 32; i++) seq[i] = 32'h0000_0F00;
    seq[2] = 32'h0000_0055;
    run_cmd(1, 3, 10, 32'h55, 32'hFF, 3, 5, "abort_wait");

    // CHK mismatch, L=0 treated as 1, STABLE full-length at max limit
    seq[0] = 32'h0000_0001;
    run_cmd(0, 4, 0, 32'h0, 32'h1, 0, 0, "chk_miss");
    seq[0] = 32'hFFFF_0000;
    run_cmd(1, 2, 0, 32'h0, 32'h0000_FFFF, 0, 0, "wait_l0_hit");
    seq[0] = 32'hFFFF_0001;
    run_cmd(1, 2, 0, 32'h0, 32'h0000_FFFF, 0, 0, "wait_l0_miss");
    for (int i = 0; i < 32; i++) seq[i] = 32'h00AB_0000 | ($urandom() & 32'h0000_FFFF);
    run_cmd(2, 0, CNT_MAX, 32'h00AB_0000, 32'hFFFF_0000, 0, 0, "stable_full");

    // Reset while running
    for (int i = 0; i < 32; i++) seq[i] = 32'h0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_idx = 3'd1; cmd_value = '0;
    cmd_mask = '1; cmd_cycles = NW'(CNT_MAX);
    set_bus(1, 32'h0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_mid_run", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    check("rst_mid_run", 64'({busy, rsp_valid, cmd_ready}), 64'(3'b001));
    check("rst_mid_run_cnts", 64'({pass_cnt, fail_cnt}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_run_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    // Randomized commands
    for (int t = 0; t < 40; t++) begin
      op  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      idx = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, CS - 1));
      l   = int'($urandom_range(0, CNT_MAX));
      v   = $urandom();
      m   = $urandom() | 32'h0000_0001;
      for (int i = 0; i < 32; i++)
        seq[i] = ($urandom_range(0, 5) == 0) ? $urandom() : ((v & m) | ($urandom() & ~m));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_cmd(op, idx, l, v, m, ab, int'($urandom_range(0, 3)), "rand");
    end

    // Drive pass count into saturation
    for (int t = 0; t < CNT_MAX + 2; t++) begin
      seq[0] = $urandom();
      run_cmd(0, t % CS, 1, seq[0], 32'hFFFF_FFFF, 0, 0, "sat_pass");
    end
    check("pass_saturated", 64'(pass_cnt), 64'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
